// File: rtl/project_soc_pio_pkg.sv
// Shared constants for the SoC output PIO: register map and pulse length limit.
package project_soc_pio_pkg;

  // Word addresses of the four slave registers.
  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_SET   = 2'd1;
  localparam logic [1:0] ADDR_CLR   = 2'd2;
  localparam logic [1:0] ADDR_PULSE = 2'd3;

  // Longest supported pulse, in clk cycles (24-bit counter).
  localparam int unsigned PULSE_CYCLES_MAX = 32'd16_777_215;

  // Avalon-MM data bus width.
  localparam int unsigned BUS_W = 32;

endpackage

// File: rtl/project_soc_pio_out_if.sv
// Avalon-MM slave bus bundle for the output PIO.
//   address    : word address (2 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit combinational read data
interface project_soc_pio_out_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/project_soc_pio_pulse_timer.sv
// Shared pulse timer: one down-counter and the set of bits it keeps high.
//   clk, reset : clock, asynchronous active-high reset
//   load       : nonzero PULSE write; OR in wd and restart the full window
//   abort      : zero PULSE write; drop all pulsed bits at once
//   wd         : write data, DATA_WIDTH bits
//   mask       : currently pulsed bits (registered)
//   mask_next  : next-state mask, lets the top register out_port glitch-free
//   busy       : counter nonzero
module project_soc_pio_pulse_timer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned PULSE_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic [DATA_WIDTH-1:0] mask,
  output logic [DATA_WIDTH-1:0] mask_next,
  output logic                  busy
);
  localparam int unsigned CNT_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic                  expiring;

  always_comb begin
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    expiring = (cnt_q == CNT_ONE);
    if (abort) begin
      cnt_d  = '0;
      mask_d = '0;
    end else if (load) begin
      // A write landing on the expiry edge wins, but the expiring bits drop.
      mask_d = expiring ? wd : (mask_q | wd);
      cnt_d  = CNT_LOAD;
    end else if (expiring) begin
      cnt_d  = '0;
      mask_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      mask_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
    end
  end

  assign mask      = mask_q;
  assign mask_next = mask_d;
  assign busy      = (cnt_q != '0);

endmodule

// File: rtl/project_soc_pio_out.sv
// Avalon-MM output PIO with atomic set/clear and a timed auto-clearing pulse channel.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : zero-wait-state Avalon-MM slave (DATA/SET/CLEAR/PULSE registers)
//   out_port   : registered output, data_reg | pulse_mask
//   pulse_busy : high while a pulse is active
module project_soc_pio_out
  import project_soc_pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter logic [31:0] RESET_VALUE  = 32'h0,
  parameter int unsigned PULSE_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  project_soc_pio_out_if.slave  bus,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  pulse_busy
);
  localparam logic [DATA_WIDTH-1:0] RST_DATA = RESET_VALUE[DATA_WIDTH-1:0];

  logic                  wr;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] mask, mask_next;
  logic                  busy;
  logic                  pulse_wr;
  logic [BUS_W-1:0]      rdata;
  logic                  unused_wd;

  assign wr        = bus.chipselect && !bus.write_n;
  assign wd        = bus.writedata[DATA_WIDTH-1:0];
  // Bits above DATA_WIDTH are deliberately ignored.
  assign unused_wd = ^bus.writedata;
  assign pulse_wr  = wr && (bus.address == ADDR_PULSE);

  always_comb begin
    data_d = data_q;
    if (wr) begin
      case (bus.address)
        ADDR_DATA: data_d = wd;
        ADDR_SET:  data_d = data_q | wd;
        ADDR_CLR:  data_d = data_q & ~wd;
        default:   data_d = data_q;
      endcase
    end
  end

  project_soc_pio_pulse_timer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (pulse_wr && (wd != '0)),
    .abort     (pulse_wr && (wd == '0)),
    .wd        (wd),
    .mask      (mask),
    .mask_next (mask_next),
    .busy      (busy)
  );

  // out_port is loaded from next-state values so it moves on the write edge itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RST_DATA;
      out_q  <= RST_DATA;
    end else begin
      data_q <= data_d;
      out_q  <= data_d | mask_next;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_DATA:  rdata[DATA_WIDTH-1:0] = data_q;
      ADDR_SET:   rdata[DATA_WIDTH-1:0] = out_q;
      ADDR_CLR:   rdata[DATA_WIDTH-1:0] = mask;
      ADDR_PULSE: rdata[0]              = busy;
      default:    rdata                 = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign out_port     = out_q;
  assign pulse_busy   = busy;

endmodule

// File: tb/tb_project_soc_pio_out.sv
module tb_project_soc_pio_out;
  localparam int unsigned      DW = 8;
  localparam int unsigned      P  = 4;
  localparam logic [DW-1:0]    RV = 8'hA5;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] out_port;
  logic          pulse_busy;

  project_soc_pio_out_if bus ();

  project_soc_pio_out #(
    .DATA_WIDTH   (DW),
    .RESET_VALUE  (32'(RV)),
    .PULSE_CYCLES (P)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .out_port   (out_port),
    .pulse_busy (pulse_busy)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pulse state is a set of bits plus an absolute deadline in edges.
  int unsigned   now = 0;
  int unsigned   deadline = 0;
  logic [DW-1:0] data_m;
  logic [DW-1:0] mask_m;

  function automatic bit active();
    return now < deadline;
  endfunction

  function automatic logic [DW-1:0] exp_out();
    return data_m | (active() ? mask_m : '0);
  endfunction

  function automatic logic [31:0] exp_rd(input int a);
    case (a)
      0:       return 32'(data_m);
      1:       return 32'(exp_out());
      2:       return 32'(active() ? mask_m : '0);
      default: return {31'b0, active()};
    endcase
  endfunction

  task automatic model_reset();
    data_m   = RV;
    mask_m   = '0;
    deadline = now;
  endtask

  task automatic model_write(input logic [1:0] a, input logic [31:0] wdata);
    logic [DW-1:0] w;
    w = wdata[DW-1:0];
    case (a)
      2'd0: data_m = w;
      2'd1: data_m = data_m | w;
      2'd2: data_m = data_m & ~w;
      default: begin
        if (w == '0) begin
          mask_m   = '0;
          deadline = now;
        end else begin
          mask_m   = active() ? (mask_m | w) : w;
          deadline = now + P;
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called after a negedge; reads all four registers combinationally.
  task automatic check_all();
    chk("out_port", 32'(out_port), 32'(exp_out()));
    chk("pulse_busy", 32'(pulse_busy), 32'(active()));
    for (int a = 0; a < 4; a++) begin
      bus.address = 2'(a);
      #1;
      chk($sformatf("read@%0d", a), bus.readdata, exp_rd(a));
    end
  endtask

  // One clock cycle, optionally carrying a write; checks the result after the edge.
  task automatic cycle(input bit wr, input logic [1:0] a, input logic [31:0] wdata);
    bus.chipselect = wr;
    bus.write_n    = !wr;
    bus.address    = a;
    bus.writedata  = wdata;
    @(posedge clk);
    now++;
    if (wr) model_write(a, wdata);
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    check_all();
  endtask

  initial begin
    logic [31:0] rw;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    reset          = 1'b1;
    model_reset();
    @(negedge clk);
    chk("reset_out", 32'(out_port), 32'h0000_00A5);
    chk("reset_busy", 32'(pulse_busy), 32'd0);
    check_all();
    reset = 1'b0;

    // DATA / SET / CLEAR, upper writedata bits ignored.
    cycle(1, 2'd0, 32'hDEAD_BE0F);
    cycle(1, 2'd1, 32'hFFFF_0030);
    cycle(1, 2'd2, 32'h1234_5603);
    chk("dsc_out", 32'(out_port), 32'h3C);
    bus.address = 2'd0; #1;
    chk("dsc_read0", bus.readdata, 32'h3C);
    bus.address = 2'd1; #1;
    chk("dsc_read1", bus.readdata, 32'h3C);

    // Single 4-cycle pulse from data = 0.
    cycle(1, 2'd0, 32'h0);
    cycle(1, 2'd3, 32'h01);
    chk("pulse_n_out", 32'(out_port), 32'h01);
    bus.address = 2'd2; #1;
    chk("pulse_read2", bus.readdata, 32'h01);
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 2'd0, 32'h0);
      chk($sformatf("pulse_n+%0d", i), 32'(out_port), (i < 4) ? 32'h01 : 32'h00);
    end

    // Re-trigger two cycles in, then a write exactly on the expiry edge.
    cycle(1, 2'd3, 32'h01);
    cycle(0, 2'd0, 32'h0);
    cycle(1, 2'd3, 32'h02);
    for (int i = 1; i <= 3; i++) cycle(0, 2'd0, 32'h0);
    chk("retrig_both", 32'(out_port), 32'h03);
    cycle(1, 2'd3, 32'h04);
    chk("expiry_write", 32'(out_port), 32'h04);
    chk("expiry_busy", 32'(pulse_busy), 32'd1);
    for (int i = 1; i <= 4; i++) cycle(0, 2'd0, 32'h0);
    chk("expiry_done", 32'(out_port), 32'h00);

    // Abort mid-pulse.
    cycle(1, 2'd3, 32'h81);
    cycle(1, 2'd3, 32'hFFFF_FF00);
    chk("abort_out", 32'(out_port), 32'h00);
    chk("abort_busy", 32'(pulse_busy), 32'd0);

    // CLEAR of a pulsed bit holds it until expiry.
    cycle(1, 2'd0, 32'h01);
    cycle(1, 2'd3, 32'h01);
    cycle(1, 2'd2, 32'h01);
    chk("clr_in_pulse", 32'(out_port), 32'h01);
    for (int i = 1; i <= 3; i++) cycle(0, 2'd0, 32'h0);
    chk("clr_after", 32'(out_port), 32'h00);

    // Asynchronous reset mid-pulse.
    cycle(1, 2'd0, 32'h10);
    cycle(1, 2'd3, 32'h0F);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_out", 32'(out_port), 32'(RV));
    chk("rst_mid_busy", 32'(pulse_busy), 32'd0);
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 7))
        0:       rw = 32'h0;
        1, 2:    rw = 32'h1 << $urandom_range(0, 7);
        default: rw = $urandom;
      endcase
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/project_soc_pio_out.md
# project_soc_pio_out

Parametrised Avalon-MM output PIO for the SoC: a DATA_WIDTH-bit output register with atomic bit-set, bit-clear and a timed auto-clearing pulse channel. It hangs off the system interconnect as a zero-wait-state slave. It drives board-level control lines such as peripheral resets, enables and strobes, where firmware needs glitch-free, read-modify-write-free updates.

## Interface
Parameters:
- DATA_WIDTH, 8, output width, 1..32
- RESET_VALUE, 0, DATA register and out_port value after reset
- PULSE_CYCLES, 1000, pulse length in clk cycles, 1..2^24-1; counter width CNT_W = $clog2(PULSE_CYCLES+1)

Ports:
- clk  in  1  single clock; one clock for the whole block
- reset  in  1  asynchronous, active-high reset
- address  in  2  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; a write is chipselect && !write_n
- writedata  in  32  write data; bits above DATA_WIDTH are ignored
- readdata  out  32  read data, combinational from address, zero-extended
- out_port  out  DATA_WIDTH  registered output = data_reg | pulse_mask
- pulse_busy  out  1  high while a pulse is active

## Operation
- Register map:
  - Address 0, DATA: write sets data_reg = wd. Read returns data_reg.
  - Address 1, SET: write sets data_reg |= wd. Read returns out_port.
  - Address 2, CLEAR: write sets data_reg &= ~wd. Read returns pulse_mask.
  - Address 3, PULSE: write of nonzero wd sets pulse_mask |= wd and loads the counter with PULSE_CYCLES. Write of wd == 0 aborts: mask = 0, counter = 0. Read returns {31'b0, pulse_busy}.
- Pulse timer:
  - The counter decrements by 1 each cycle while nonzero.
  - On the edge where counter == 1, the counter goes to 0 and pulse_mask clears.
  - pulse_busy = (counter != 0).
  - The timer is shared: one counter for all pulsed bits.
- Re-trigger: a PULSE write during an active pulse ORs in the new bits and restarts the full PULSE_CYCLES window for all pulsed bits.
- Simultaneous expiry and PULSE write on the same edge: the write wins. pulse_mask = wd (old bits drop) and the counter = PULSE_CYCLES.
- DATA/SET/CLEAR writes during a pulse modify data_reg only. Pulsed bits stay high until expiry, then out_port reflects data_reg.
- Reset (asynchronous, any time, including mid-pulse):
  - data_reg = RESET_VALUE, out_port = RESET_VALUE
  - pulse_mask = 0, counter = 0, pulse_busy = 0
  - readdata is then determined by address alone.

## Timing
- Writes commit on the rising clk edge sampling the write.
- out_port is a flop loaded from the next-state value, so it changes on that same edge: zero added latency and no combinational glitches.
- Reads are zero-wait and combinational; a read in the cycle after a write returns the updated value.
- A pulse written at edge N holds the bits high for exactly PULSE_CYCLES clk periods. They fall at edge N+PULSE_CYCLES.
- With PULSE_CYCLES = 1, the pulse is exactly one cycle.
- No back-pressure: every write is accepted, and each access takes one cycle.

## Structure
- Shared package project_soc_pio_pkg holds:
  - ADDR_DATA = 2'd0, ADDR_SET = 2'd1, ADDR_CLR = 2'd2, ADDR_PULSE = 2'd3
  - a PULSE_CYCLES maximum constant
- One sub-module, project_soc_pio_pulse_timer, containing the counter and pulse_mask.
  - Inputs: load, abort, wd.
  - Outputs: mask, busy.
  - It contains the expiry/write priority logic.
- The top level holds data_reg, the write decode, the out_port flop and the read mux.

## Test plan
- Reset with RESET_VALUE = 8'hA5 → out_port = A5, readdata@0 = A5, pulse_busy = 0. Assert reset mid-pulse → mask and busy clear immediately.
- Write DATA 8'h0F, SET 8'h30, CLEAR 8'h03 → out_port = 8'h3C. Reads at addresses 0 and 1 both return 0x3C. Writedata bits [31:8] have no effect.
- PULSE_CYCLES = 4, data = 0, write PULSE 8'h01 at edge N → out_port[0] high for edges N..N+3 and low at N+4. pulse_busy mirrors this; read@2 = 0x01 during the pulse.
- Re-trigger: write PULSE 8'h02 two cycles into a 4-cycle pulse of 8'h01 → both bits high, falling together 4 cycles after the second write. Write PULSE 8'h04 exactly on the expiry edge → only bit 2 is high for 4 more cycles.
- Write PULSE 0 mid-pulse → mask clears on that edge and busy = 0. A CLEAR of a pulsed bit during the pulse leaves it high until expiry.
- DATA_WIDTH = 1 and DATA_WIDTH = 32 builds pass the same scenarios. With PULSE_CYCLES = 1, the pulse is exactly one cycle.
